// File: rtl/datamem_arbiter.sv
// Two-port round-robin arbiter with lock support in front of the data memory.
// Range-checks each access and returns read data/error one cycle after acceptance.
module datamem_arbiter #(
  parameter int unsigned MEM_SIZE         = 131072,
  parameter int unsigned USABLE_MEM_START = 32'h10000,
  parameter int unsigned LOCK_TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic [31:0] req_addr_0,
  input  logic [31:0] req_wdata_0,
  input  logic        req_wen_0,
  input  logic        req_lock_0,
  output logic        rsp_valid_0,
  output logic [31:0] rsp_rdata_0,
  output logic        rsp_err_0,
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic [31:0] req_addr_1,
  input  logic [31:0] req_wdata_1,
  input  logic        req_wen_1,
  input  logic        req_lock_1,
  output logic        rsp_valid_1,
  output logic [31:0] rsp_rdata_1,
  output logic        rsp_err_1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  input  logic [31:0] mem_dout
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKED_0,
    LOCKED_1
  } lock_e;

  lock_e            lock_q, lock_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  logic             rsp_valid_0_q, rsp_valid_1_q;
  logic [31:0]      rsp_rdata_0_q, rsp_rdata_0_d;
  logic [31:0]      rsp_rdata_1_q, rsp_rdata_1_d;
  logic             rsp_err_0_q, rsp_err_0_d;
  logic             rsp_err_1_q, rsp_err_1_d;

  logic             gnt0, gnt1, gnt_any;
  logic [31:0]      sel_addr, sel_wdata;
  logic             sel_wen, sel_lock, legal;
  logic [32:0]      addr_end;
  logic [31:0]      rsp_data;

  // Grant selection: round-robin when unlocked, owner-only when locked.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (lock_q)
        UNLOCKED: begin
          if (req_valid_0 && req_valid_1) begin
            gnt0 = last_grant_q;
            gnt1 = !last_grant_q;
          end else begin
            gnt0 = req_valid_0;
            gnt1 = req_valid_1;
          end
        end
        LOCKED_0: gnt0 = req_valid_0;
        LOCKED_1: gnt1 = req_valid_1;
        default: ;
      endcase
    end
  end

  assign gnt_any   = gnt0 | gnt1;
  assign sel_addr  = gnt1 ? req_addr_1  : req_addr_0;
  assign sel_wdata = gnt1 ? req_wdata_1 : req_wdata_0;
  assign sel_wen   = gnt1 ? req_wen_1   : req_wen_0;
  assign sel_lock  = gnt1 ? req_lock_1  : req_lock_0;

  // 33-bit end address so accesses wrapping past 4 GiB are rejected.
  assign addr_end = {1'b0, sel_addr} + 33'd3;
  assign legal    = (sel_addr >= USABLE_MEM_START) &&
                    (addr_end <= (33'(MEM_SIZE) - 33'd1));
  assign rsp_data = legal ? mem_dout : 32'h0;

  assign req_ready_0 = gnt0;
  assign req_ready_1 = gnt1;
  assign mem_addr    = gnt_any ? sel_addr  : 32'h0;
  assign mem_wdata   = gnt_any ? sel_wdata : 32'h0;
  assign mem_wen     = gnt_any & sel_wen & legal;

  // Lock FSM and round-robin pointer next state.
  always_comb begin
    lock_d       = lock_q;
    idle_cnt_d   = idle_cnt_q;
    last_grant_d = last_grant_q;
    if (gnt_any) begin
      last_grant_d = gnt1;
    end
    case (lock_q)
      UNLOCKED: begin
        idle_cnt_d = '0;
        if (gnt_any && sel_lock) begin
          lock_d = gnt1 ? LOCKED_1 : LOCKED_0;
        end
      end
      LOCKED_0, LOCKED_1: begin
        if (gnt_any) begin
          idle_cnt_d = '0;
          if (!sel_lock) begin
            lock_d = UNLOCKED;
          end
        end else if (idle_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          lock_d     = UNLOCKED;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        lock_d     = UNLOCKED;
        idle_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    rsp_rdata_0_d = rsp_rdata_0_q;
    rsp_err_0_d   = rsp_err_0_q;
    rsp_rdata_1_d = rsp_rdata_1_q;
    rsp_err_1_d   = rsp_err_1_q;
    if (gnt0) begin
      rsp_rdata_0_d = rsp_data;
      rsp_err_0_d   = !legal;
    end
    if (gnt1) begin
      rsp_rdata_1_d = rsp_data;
      rsp_err_1_d   = !legal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q        <= UNLOCKED;
      last_grant_q  <= 1'b1;
      idle_cnt_q    <= '0;
      rsp_valid_0_q <= 1'b0;
      rsp_valid_1_q <= 1'b0;
      rsp_rdata_0_q <= 32'h0;
      rsp_rdata_1_q <= 32'h0;
      rsp_err_0_q   <= 1'b0;
      rsp_err_1_q   <= 1'b0;
    end else begin
      lock_q        <= lock_d;
      last_grant_q  <= last_grant_d;
      idle_cnt_q    <= idle_cnt_d;
      rsp_valid_0_q <= gnt0;
      rsp_valid_1_q <= gnt1;
      rsp_rdata_0_q <= rsp_rdata_0_d;
      rsp_rdata_1_q <= rsp_rdata_1_d;
      rsp_err_0_q   <= rsp_err_0_d;
      rsp_err_1_q   <= rsp_err_1_d;
    end
  end

  assign rsp_valid_0 = rsp_valid_0_q;
  assign rsp_rdata_0 = rsp_rdata_0_q;
  assign rsp_err_0   = rsp_err_0_q;
  assign rsp_valid_1 = rsp_valid_1_q;
  assign rsp_rdata_1 = rsp_rdata_1_q;
  assign rsp_err_1   = rsp_err_1_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Scoreboard testbench for datamem_arbiter with a byte-addressed memory model.
// Expected responses are queued per requester at grant time and compared on rsp_valid.
module tb_datamem_arbiter;

  localparam int unsigned MEM_SIZE     = 131072;
  localparam int unsigned START        = 32'h10000;
  localparam int unsigned LOCK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_0, req_ready_0, req_wen_0, req_lock_0;
  logic [31:0] req_addr_0, req_wdata_0;
  logic        rsp_valid_0, rsp_err_0;
  logic [31:0] rsp_rdata_0;
  logic        req_valid_1, req_ready_1, req_wen_1, req_lock_1;
  logic [31:0] req_addr_1, req_wdata_1;
  logic        rsp_valid_1, rsp_err_1;
  logic [31:0] rsp_rdata_1;
  logic [31:0] mem_addr, mem_wdata, mem_dout;
  logic        mem_wen;

  logic        preloadEn = 1'b0;
  logic [31:0] preloadAddr = '0;
  logic [31:0] preloadData = '0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } rsp_t;

  rsp_t        q0[$];
  rsp_t        q1[$];
  logic [31:0] refMem[int unsigned];
  int          cycle = 0;
  int          vectors = 0;
  int          miscompares = 0;

  logic [7:0]  mem [0:MEM_SIZE-1];

  always #5 clk = ~clk;

  datamem_arbiter #(
    .MEM_SIZE(MEM_SIZE),
    .USABLE_MEM_START(START),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_addr_0(req_addr_0),
    .req_wdata_0(req_wdata_0), .req_wen_0(req_wen_0), .req_lock_0(req_lock_0),
    .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0), .rsp_err_0(rsp_err_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_addr_1(req_addr_1),
    .req_wdata_1(req_wdata_1), .req_wen_1(req_wen_1), .req_lock_1(req_lock_1),
    .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1), .rsp_err_1(rsp_err_1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_dout(mem_dout)
  );

  // Memory model: combinational read, write commits on the rising edge.
  assign mem_dout = (mem_addr <= MEM_SIZE - 4) ?
                    {mem[mem_addr[16:0] + 17'd3], mem[mem_addr[16:0] + 17'd2],
                     mem[mem_addr[16:0] + 17'd1], mem[mem_addr[16:0]]} : 32'h0;

  always @(posedge clk) begin
    if (preloadEn) begin
      for (int b = 0; b < 4; b++) mem[preloadAddr[16:0] + 17'(b)] <= preloadData[8*b +: 8];
    end else if (mem_wen && mem_addr <= MEM_SIZE - 4) begin
      for (int b = 0; b < 4; b++) mem[mem_addr[16:0] + 17'(b)] <= mem_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  function automatic logic isLegal(input logic [31:0] a);
    logic [32:0] e;
    e = {1'b0, a} + 33'd3;
    return (a >= START) && (e <= 33'(MEM_SIZE - 1));
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : 32'h0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    preloadEn   = 1'b1;
    preloadAddr = a;
    preloadData = d;
    refMem[a]   = d;
    @(posedge clk);
    #1;
    preloadEn = 1'b0;
  endtask

  task automatic setReq0(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic l);
    req_valid_0 = v; req_addr_0 = a; req_wdata_0 = d; req_wen_0 = w; req_lock_0 = l;
  endtask

  task automatic setReq1(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic l);
    req_valid_1 = v; req_addr_1 = a; req_wdata_1 = d; req_wen_1 = w; req_lock_1 = l;
  endtask

  task automatic pushRsp(input int k, input logic [31:0] a, input logic w,
                         input logic [31:0] d);
    rsp_t item;
    item.err   = !isLegal(a);
    item.rdata = item.err ? 32'h0 : refRead(a);
    item.due   = cycle + 1;
    if (!item.err && w) refMem[a] = d;
    if (k == 0) q0.push_back(item);
    else q1.push_back(item);
  endtask

  // One cycle: check grant and memory drive mid-cycle, queue the expected response.
  task automatic applyStimulus(input logic expReady0, input logic expReady1);
    logic [31:0] expAddr, expWdata;
    logic        expWen;
    expAddr = '0; expWdata = '0; expWen = 1'b0;
    @(negedge clk);
    checkOutput("ready0", 32'(req_ready_0), 32'(expReady0));
    checkOutput("ready1", 32'(req_ready_1), 32'(expReady1));
    if (expReady0) begin
      expAddr = req_addr_0; expWdata = req_wdata_0;
      expWen = req_wen_0 && isLegal(req_addr_0);
      pushRsp(0, req_addr_0, req_wen_0, req_wdata_0);
    end else if (expReady1) begin
      expAddr = req_addr_1; expWdata = req_wdata_1;
      expWen = req_wen_1 && isLegal(req_addr_1);
      pushRsp(1, req_addr_1, req_wen_1, req_wdata_1);
    end
    checkOutput("mem_wen", 32'(mem_wen), 32'(expWen));
    checkOutput("mem_addr", mem_addr, expAddr);
    checkOutput("mem_wdata", mem_wdata, expWdata);
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest due entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid_0) begin
        if (q0.size() == 0 || q0[0].due > cycle) begin
          checkOutput("rsp0_unexpected", 32'(rsp_valid_0), 32'd0);
        end else begin
          checkOutput("rsp0_rdata", rsp_rdata_0, q0[0].rdata);
          checkOutput("rsp0_err", 32'(rsp_err_0), 32'(q0[0].err));
          void'(q0.pop_front());
        end
      end else if (q0.size() > 0 && q0[0].due <= cycle) begin
        checkOutput("rsp0_missing", 32'(rsp_valid_0), 32'd1);
        void'(q0.pop_front());
      end
      if (rsp_valid_1) begin
        if (q1.size() == 0 || q1[0].due > cycle) begin
          checkOutput("rsp1_unexpected", 32'(rsp_valid_1), 32'd0);
        end else begin
          checkOutput("rsp1_rdata", rsp_rdata_1, q1[0].rdata);
          checkOutput("rsp1_err", 32'(rsp_err_1), 32'(q1[0].err));
          void'(q1.pop_front());
        end
      end else if (q1.size() > 0 && q1[0].due <= cycle) begin
        checkOutput("rsp1_missing", 32'(rsp_valid_1), 32'd1);
        void'(q1.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    setReq0(1'b0, '0, '0, 1'b0, 1'b0);
    setReq1(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    preload(32'h10000, 32'hDEADBEEF);
    preload(32'h10004, 32'hA5A50004);
    preload(32'h10008, 32'h0BADF00D);
    preload(32'h10010, 32'h11111111);
    preload(32'h1FFFC, 32'h77777777);

    $display("[TB] reset behaviour");
    setReq0(1'b1, 32'h10000, 32'h1, 1'b1, 1'b1);
    setReq1(1'b1, 32'h10008, 32'h2, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rst_rsp_valid0", 32'(rsp_valid_0), 32'd0);
    checkOutput("rst_rsp_valid1", 32'(rsp_valid_1), 32'd0);
    checkOutput("rst_rsp_rdata0", rsp_rdata_0, 32'h0);
    checkOutput("rst_rsp_rdata1", rsp_rdata_1, 32'h0);
    checkOutput("rst_rsp_err0", 32'(rsp_err_0), 32'd0);
    checkOutput("rst_rsp_err1", 32'(rsp_err_1), 32'd0);
    rst = 1'b0;

    $display("[TB] contention");
    setReq0(1'b1, 32'h10000, '0, 1'b0, 1'b0);
    setReq1(1'b1, 32'h10008, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);

    $display("[TB] solo read and write-then-read");
    setReq1(1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    setReq0(1'b0, '0, '0, 1'b0, 1'b0);
    setReq1(1'b1, 32'h10004, 32'h12345678, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    setReq1(1'b0, '0, '0, 1'b0, 1'b0);
    setReq0(1'b1, 32'h10004, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);

    $display("[TB] range checks");
    setReq0(1'b1, MEM_SIZE - 4, 32'hCAFEF00D, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    setReq0(1'b0, '0, '0, 1'b0, 1'b0);
    setReq1(1'b1, MEM_SIZE - 4, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    setReq1(1'b0, '0, '0, 1'b0, 1'b0);
    setReq0(1'b1, 32'h0FFFF, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    setReq0(1'b0, '0, '0, 1'b0, 1'b0);
    setReq1(1'b1, MEM_SIZE - 3, 32'hAAAAAAAA, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    setReq1(1'b0, '0, '0, 1'b0, 1'b0);
    setReq0(1'b1, 32'hFFFFFFFE, 32'hBBBBBBBB, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    setReq0(1'b0, '0, '0, 1'b0, 1'b0);
    setReq1(1'b1, 32'h10008, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);

    $display("[TB] lock released by request");
    setReq0(1'b1, 32'h10000, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    setReq0(1'b1, 32'h10010, 32'h55AA55AA, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    setReq0(1'b1, 32'h10010, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    setReq1(1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);

    $display("[TB] lock released by timeout");
    setReq0(1'b1, 32'h10000, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    setReq0(1'b0, '0, '0, 1'b0, 1'b0);
    setReq1(1'b1, 32'h10008, '0, 1'b0, 1'b0);
    for (int i = 0; i < LOCK_TIMEOUT; i++) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);

    $display("[TB] lock dropped by reset");
    setReq0(1'b1, 32'h10004, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    setReq0(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1);
    setReq1(1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    checkOutput("sb0_drained", 32'(q0.size()), 32'd0);
    checkOutput("sb1_drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Two-port arbiter placed in front of the byte-addressed data memory, sharing its single access port between requester 0 (CPU load/store path) and requester 1 (debug/DMA loader). It grants one 32-bit access per cycle using round-robin priority with an optional lock for atomic read-modify-write sequences. It range-checks every address against the usable memory window, and returns read data and an error flag through a registered response one cycle after acceptance.

## Interface
- MEM_SIZE, 131072: memory size in bytes.
- USABLE_MEM_START, 'h10000: lowest legal byte address.
- LOCK_TIMEOUT, 16: idle cycles after which a held lock is forcibly released (≥1).
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid_0 / req_valid_1  in  1  access request.
- req_ready_0 / req_ready_1  out  1  grant; request accepted when valid & ready.
- req_addr_0 / req_addr_1  in  32  byte address of the 4-byte access.
- req_wdata_0 / req_wdata_1  in  32  write data; byte 0 goes to addr, byte 3 goes to addr+3.
- req_wen_0 / req_wen_1  in  1  1 = write, 0 = read.
- req_lock_0 / req_lock_1  in  1  keep ownership after this access.
- rsp_valid_0 / rsp_valid_1  out  1  one-cycle response strobe.
- rsp_rdata_0 / rsp_rdata_1  out  32  read data; memory contents before any write in the same access.
- rsp_err_0 / rsp_err_1  out  1  access out of range; no write performed.
- mem_addr  out  32  to memory address.
- mem_wdata  out  32  to memory write data.
- mem_wen  out  1  to memory write enable.
- mem_dout  in  32  combinational memory read data.

## Operation
- Registered state:
  - last_grant (1 bit, reset 1).
  - lock_owner: NONE/R0/R1, reset NONE.
  - idle_cnt (for lock timeout).
  - Response registers.
- Lock FSM states:
  - UNLOCKED: arbitration is round-robin. If both requesters are valid, grant goes to the requester other than last_grant. If only one is valid, that one is granted.
  - LOCKED_k: only requester k can be granted. req_ready of the other requester is 0.
- Lock FSM transitions:
  - UNLOCKED → LOCKED_k: accepted request from k with req_lock_k=1.
  - LOCKED_k → LOCKED_k: accepted request from k with req_lock_k=1. Resets idle_cnt.
  - LOCKED_k → UNLOCKED, either condition:
    - accepted request from k with req_lock_k=0;
    - idle_cnt reaches LOCK_TIMEOUT. idle_cnt counts cycles with req_valid_k=0 while LOCKED_k.
- last_grant updates to the granted requester on every accepted request.
- Grant and memory drive (combinational):
  - req_ready_k = 1 only for the granted requester, and only when its req_valid_k=1.
  - mem_addr and mem_wdata mux from the granted requester.
  - With no grant: mem_addr=0, mem_wdata=0, mem_wen=0.
- Range check: legal iff addr ≥ USABLE_MEM_START and addr+3 ≤ MEM_SIZE-1. Use 33-bit compare so wrap at 'hFFFFFFFD+ is illegal.
  - Illegal access: mem_wen forced to 0, request still accepted, rsp_err_k=1, rsp_rdata_k=0. Lock rules still apply.
- mem_wen = granted & req_wen & legal.
- Response: the cycle after acceptance, rsp_valid_k=1. rsp_rdata_k is mem_dout captured in the accept cycle, for both reads and writes. There is no response backpressure.

## Timing
- Cycle N: valid & ready. Memory is addressed. A write commits at the rising edge ending cycle N.
- Cycle N+1: rsp_valid_k, rsp_rdata_k and rsp_err_k are valid for exactly one cycle. Otherwise rsp_valid_k=0 and rsp_rdata_k/rsp_err_k hold their values.
- Throughput is one access per cycle aggregate. With both requesters valid, grants alternate every cycle.
- A read issued in cycle N+1 to a location written in cycle N returns the new data.
- Reset:
  - While rst=1: req_ready_*=0, mem_wen=0.
  - After the reset edge: rsp_valid_*=0, rsp_rdata_*=0, rsp_err_*=0, lock_owner=NONE, last_grant=1, idle_cnt=0.
  - Reset mid-lock drops the lock. A response pending at reset is discarded.
- The lock is evaluated using the registered state only. A lock request and a competing request in the same cycle resolve by round-robin first.

## Test plan
- Solo read: R0 reads 'h10000 holding 'hDEADBEEF → ready_0 in the same cycle; next cycle rsp_valid_0=1, rdata='hDEADBEEF, err=0.
- Contention: both valid for 4 cycles, first grant after reset → grants R0,R1,R0,R1; each rsp_valid pulses the cycle after its grant.
- Write then read: R1 writes 'h12345678 to 'h10004, R0 reads 'h10004 the next cycle → rdata='h12345678. The write's own rsp_rdata equals the old contents.
- Range errors: both legal boundaries, USABLE_MEM_START and MEM_SIZE-4, are accepted normally. Illegal addresses:
  - read of 'h0FFFF → err=1, rdata=0, mem_wen stays 0;
  - write to MEM_SIZE-3 → err=1, rdata=0, mem_wen stays 0;
  - write to 'hFFFFFFFE → err=1, rdata=0, mem_wen stays 0.
- Lock, release by request: R0 locked read, then R0 write with lock=0, while R1 is continuously valid → R1 is not granted until the cycle after R0's unlocking write.
- Lock, release by timeout and reset: R0 locks then goes idle with R1 valid → R1 is granted after exactly LOCK_TIMEOUT idle cycles. Asserting rst mid-lock → lock clears and R1 is granted the first cycle after reset deasserts.
